// File: rtl/snitch_icache_pkg.sv
// Shared types and helpers for the L1 instruction-cache blocks.
package snitch_icache_pkg;

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} icache_arb_state_e;

  // The lookup ID carries the requester index above the requester's own ID.
  function automatic int unsigned lk_id_width(input int unsigned id_w, input int unsigned nr_ports);
    return (nr_ports > 1) ? id_w + $clog2(nr_ports) : id_w;
  endfunction

  function automatic int unsigned idx_width(input int unsigned nr_ports);
    return (nr_ports > 1) ? $clog2(nr_ports) : 1;
  endfunction

endpackage

// File: rtl/snitch_icache_lookup_arbiter_if.sv
// Bundle of fetch-side, lookup-side and flush handshakes around the lookup arbiter.
interface snitch_icache_lookup_arbiter_if
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS    = 2,
  parameter int unsigned FETCH_AW    = 32,
  parameter int unsigned ID_WIDTH    = 4,
  parameter int unsigned LINE_WIDTH  = 64,
  parameter int unsigned LK_ID_WIDTH = lk_id_width(ID_WIDTH, NR_PORTS)
);
  logic [NR_PORTS-1:0][FETCH_AW-1:0] req_addr_i;
  logic [NR_PORTS-1:0][ID_WIDTH-1:0] req_id_i;
  logic [NR_PORTS-1:0]               req_valid_i;
  logic [NR_PORTS-1:0]               req_ready_o;

  logic [FETCH_AW-1:0]               rsp_addr_o;
  logic [ID_WIDTH-1:0]               rsp_id_o;
  logic                              rsp_hit_o;
  logic [LINE_WIDTH-1:0]             rsp_data_o;
  logic                              rsp_error_o;
  logic [NR_PORTS-1:0]               rsp_valid_o;
  logic [NR_PORTS-1:0]               rsp_ready_i;

  logic [FETCH_AW-1:0]               lk_addr_o;
  logic [LK_ID_WIDTH-1:0]            lk_id_o;
  logic                              lk_valid_o;
  logic                              lk_ready_i;

  logic [FETCH_AW-1:0]               lk_addr_i;
  logic [LK_ID_WIDTH-1:0]            lk_id_i;
  logic                              lk_hit_i;
  logic [LINE_WIDTH-1:0]             lk_data_i;
  logic                              lk_error_i;
  logic                              lk_valid_i;
  logic                              lk_ready_o;

  logic                              flush_valid_i;
  logic                              flush_ready_o;
  logic                              lk_flush_valid_o;
  logic                              lk_flush_ready_i;

  // Arbiter side.
  modport slave (
    input  req_addr_i, req_id_i, req_valid_i, rsp_ready_i,
           lk_ready_i, lk_addr_i, lk_id_i, lk_hit_i, lk_data_i, lk_error_i, lk_valid_i,
           flush_valid_i, lk_flush_ready_i,
    output req_ready_o, rsp_addr_o, rsp_id_o, rsp_hit_o, rsp_data_o, rsp_error_o, rsp_valid_o,
           lk_addr_o, lk_id_o, lk_valid_o, lk_ready_o, flush_ready_o, lk_flush_valid_o
  );

  // Requesters, lookup stage and cluster side.
  modport master (
    output req_addr_i, req_id_i, req_valid_i, rsp_ready_i,
           lk_ready_i, lk_addr_i, lk_id_i, lk_hit_i, lk_data_i, lk_error_i, lk_valid_i,
           flush_valid_i, lk_flush_ready_i,
    input  req_ready_o, rsp_addr_o, rsp_id_o, rsp_hit_o, rsp_data_o, rsp_error_o, rsp_valid_o,
           lk_addr_o, lk_id_o, lk_valid_o, lk_ready_o, flush_ready_o, lk_flush_valid_o
  );
endinterface

// File: rtl/snitch_icache_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above rr_i, wrapping.
module snitch_icache_rr_pick
  import snitch_icache_pkg::*;
#(
  parameter  int unsigned NR_PORTS = 2,
  localparam int unsigned IDX_W    = idx_width(NR_PORTS)
) (
  input  logic [NR_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]    rr_i,
  output logic [IDX_W-1:0]    gnt_idx_o,
  output logic                gnt_valid_o
);
  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      cand = IDX_W'((32'(rr_i) + i) % NR_PORTS);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end
endmodule

// File: rtl/snitch_icache_lookup_arbiter.sv
// Lock-on-stall round-robin arbiter in front of the icache lookup stage, with in-flight
// bound and flush drain sequencing. Define SNITCH_ICACHE_ARB_PERF_EN to enable conflict_o.
module snitch_icache_lookup_arbiter
  import snitch_icache_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 2,
  parameter int unsigned FETCH_AW        = 32,
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned LINE_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  snitch_icache_lookup_arbiter_if.slave bus,
  output logic                          conflict_o
);
  localparam int unsigned LK_ID_WIDTH = lk_id_width(ID_WIDTH, NR_PORTS);
  localparam int unsigned IDX_W       = idx_width(NR_PORTS);
  localparam int unsigned CNT_W       = $clog2(MAX_OUTSTANDING + 1);

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  idx_t              rr_q, rr_d, pick_idx, gnt_idx, lock_idx_q, rsp_idx;
  cnt_t              cnt_q, cnt_d;
  logic              lock_q, lock_d, pick_vld, gnt_open, gnt_vld, req_hs, rsp_hs;
  logic              flush_vld_q;
  icache_arb_state_e state_q;

  snitch_icache_rr_pick #(.NR_PORTS(NR_PORTS)) i_pick (
    .req_i      (bus.req_valid_i),
    .rr_i       (rr_q),
    .gnt_idx_o  (pick_idx),
    .gnt_valid_o(pick_vld)
  );

  // A stalled lookup keeps its grant even once the counter fills or a flush starts.
  assign gnt_open = (cnt_q != cnt_t'(MAX_OUTSTANDING)) && (state_q == IDLE);
  assign gnt_idx  = lock_q ? lock_idx_q : pick_idx;
  assign gnt_vld  = lock_q ? bus.req_valid_i[lock_idx_q] : (pick_vld && gnt_open);
  assign lock_d   = gnt_vld && !bus.lk_ready_i;
  assign req_hs   = gnt_vld && bus.lk_ready_i;

  assign bus.lk_valid_o = gnt_vld;
  assign bus.lk_addr_o  = bus.req_addr_i[gnt_idx];

  if (NR_PORTS > 1) begin : g_lk_id
    assign bus.lk_id_o = {gnt_idx, bus.req_id_i[gnt_idx]};
    assign rsp_idx     = bus.lk_id_i[LK_ID_WIDTH-1 -: IDX_W];
  end else begin : g_lk_id_single
    assign bus.lk_id_o = bus.req_id_i[0];
    assign rsp_idx     = '0;
  end

  always_comb begin
    bus.req_ready_o = '0;
    if (gnt_vld) bus.req_ready_o[gnt_idx] = bus.lk_ready_i;
  end

  always_comb begin
    bus.rsp_valid_o = '0;
    bus.lk_ready_o  = 1'b0;
    if (32'(rsp_idx) < NR_PORTS) begin
      bus.rsp_valid_o[rsp_idx] = bus.lk_valid_i;
      bus.lk_ready_o           = bus.rsp_ready_i[rsp_idx];
    end
  end

  assign rsp_hs          = bus.lk_valid_i && bus.lk_ready_o;
  assign bus.rsp_addr_o  = bus.lk_addr_i;
  assign bus.rsp_id_o    = bus.lk_id_i[ID_WIDTH-1:0];
  assign bus.rsp_hit_o   = bus.lk_hit_i;
  assign bus.rsp_data_o  = bus.lk_data_i;
  assign bus.rsp_error_o = bus.lk_error_i;

  always_comb begin
    cnt_d = cnt_q;
    if (req_hs && !rsp_hs)                    cnt_d = cnt_q + cnt_t'(1);
    else if (rsp_hs && !req_hs && cnt_q != '0) cnt_d = cnt_q - cnt_t'(1);
  end

  always_comb begin
    rr_d = rr_q;
    if (req_hs) rr_d = (gnt_idx == idx_t'(NR_PORTS - 1)) ? '0 : gnt_idx + idx_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      lock_idx_q <= gnt_idx;
    end
  end

  // Drain exits on next-state values so the flush starts right after the last response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      flush_vld_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (bus.flush_valid_i) state_q <= DRAIN;
        DRAIN: if (cnt_d == '0 && !lock_d) begin
          state_q     <= FLUSH;
          flush_vld_q <= 1'b1;
        end
        FLUSH: if (bus.lk_flush_ready_i) begin
          state_q     <= IDLE;
          flush_vld_q <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          flush_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lk_flush_valid_o = flush_vld_q;
  assign bus.flush_ready_o    = flush_vld_q && bus.lk_flush_ready_i;

`ifdef SNITCH_ICACHE_ARB_PERF_EN
  logic multi_req;
  assign multi_req  = |(bus.req_valid_i & (bus.req_valid_i - NR_PORTS'(1)));
  assign conflict_o = multi_req || ((|bus.req_valid_i) && !gnt_vld);
`else
  assign conflict_o = 1'b0;
`endif

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rsp_hs && cnt_q == '0));

endmodule
